// File: rtl/alu32_stage_pkg.sv
// alu32_stage_pkg: opcodes, flag positions and the 4-bit carry-lookahead slice
package alu32_stage_pkg;
    localparam logic [2:0] OP_NOTA = 3'b000;
    localparam logic [2:0] OP_NOTB = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_SUB  = 3'b111;
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;
    typedef struct packed {
        logic       co;
        logic [3:0] s;
    } cla4_t;
    function automatic cla4_t cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [3:0] g, p;
        logic [4:0] c;
        g = a & b;
        p = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return '{co: c[4], s: p ^ c[3:0]};
    endfunction
endpackage

// File: rtl/alu32_stage_if.sv
// alu32_stage_if: operand input and result output handshakes of the ALU stage
interface alu32_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface

// File: rtl/alu32_stage_core.sv
// alu32_core: combinational 32-bit ALU producing result and NZCV flags
module alu32_core
    import alu32_stage_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic [3:0]  flags
);
    logic [31:0] bx, sum;
    logic [8:0]  c;
    logic        arith;
    // SUB reuses the adder as A + ~B + 1; op[0] selects inversion and carry-in
    assign bx    = op[0] ? ~b : b;
    assign c[0]  = op[0];
    assign arith = op[2] & op[1];
    for (genvar i = 0; i < 8; i++) begin : g_cla
        cla4_t r;
        assign r              = cla4(a[4*i +: 4], bx[4*i +: 4], c[i]);
        assign sum[4*i +: 4]  = r.s;
        assign c[i+1]         = r.co;
    end
    assign result = op == OP_NOTA ? ~a :
                    op == OP_NOTB ? ~b :
                    op == OP_AND  ? a & b :
                    op == OP_OR   ? a | b :
                    op == OP_XOR  ? a ^ b :
                    op == OP_XNOR ? ~(a ^ b) : sum;
    always_comb begin
        flags        = '0;
        flags[FLG_N] = result[31];
        flags[FLG_Z] = result == '0;
        flags[FLG_C] = arith & c[8];
        flags[FLG_V] = arith & ~(a[31] ^ bx[31]) & (sum[31] ^ a[31]);
    end
endmodule

// File: rtl/alu32_stage.sv
// alu32_stage: registered ALU stage with main+skid output buffer and delivery counter
module alu32_stage #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    alu32_stage_if.slave         bus,
    output logic [CNT_WIDTH-1:0] op_count
);
    logic [WIDTH-1:0] res, main_res, skid_res;
    logic [3:0]       flg, main_flg, skid_flg;
    logic             main_v, skid_v, acc, dlv;
    alu32_core u_core (
        .op     (bus.in_op),
        .a      (bus.in_a),
        .b      (bus.in_b),
        .result (res),
        .flags  (flg)
    );
    assign acc            = bus.in_valid && !skid_v;
    assign dlv            = main_v && bus.out_ready;
    assign bus.in_ready   = !skid_v;
    assign bus.out_valid  = main_v;
    assign bus.out_result = main_res;
    assign bus.out_flags  = main_flg;
    // main refills from skid first to keep FIFO order, else straight from the core
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v   <= 1'b0;
            skid_v   <= 1'b0;
            main_res <= '0;
            main_flg <= '0;
            skid_res <= '0;
            skid_flg <= '0;
            op_count <= '0;
        end else begin
            if ((dlv || !main_v) && (skid_v || acc)) begin
                main_res <= skid_v ? skid_res : res;
                main_flg <= skid_v ? skid_flg : flg;
            end
            if (dlv || !main_v)
                main_v <= skid_v || acc;
            if (acc && main_v && !dlv) begin
                skid_res <= res;
                skid_flg <= flg;
                skid_v   <= 1'b1;
            end else if (dlv)
                skid_v <= 1'b0;
            if (dlv && op_count != '1)
                op_count <= op_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_alu32_stage.sv
// tb_alu32_stage: directed and streaming checks of the registered ALU stage
module tb_alu32_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] op_count;
    int          nvec = 0;
    int          nerr = 0;
    alu32_stage_if bus ();
    alu32_stage dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .op_count (op_count)
    );
    always #5 clk = ~clk;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;
    vec_t vt [11];
    function automatic logic [35:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] t;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        r = '0;
        case (op)
            3'd0: r = ~a;
            3'd1: r = ~b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: begin
                t = {1'b0, a} + {1'b0, b};
                r = t[31:0];
                c = t[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: begin
                t = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = t[31:0];
                c = t[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
        endcase
        return {r[31], r == 32'd0, c, v, r};
    endfunction
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask
    task automatic test_reset;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = '0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        nvec++; if (bus.out_result !== 32'h0 || bus.out_flags !== 4'h0) begin nerr++; $display("FAIL reset_data: got %h/%h expected 0/0", bus.out_result, bus.out_flags); end
        nvec++; if (op_count !== 16'h0) begin nerr++; $display("FAIL reset_count: got %h expected 0", op_count); end
    endtask
    task automatic test_vectors;
        vt[0]  = '{3'b110, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001};
        vt[1]  = '{3'b111, 32'h12345678, 32'h12345678, 32'h00000000, 4'b0110};
        vt[2]  = '{3'b101, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 4'b1000};
        vt[3]  = '{3'b000, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 4'b1000};
        vt[4]  = '{3'b001, 32'h12345678, 32'hFFFFFFFF, 32'h00000000, 4'b0100};
        vt[5]  = '{3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 4'b0000};
        vt[6]  = '{3'b011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 4'b0000};
        vt[7]  = '{3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 4'b1000};
        vt[8]  = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110};
        vt[9]  = '{3'b111, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 4'b1000};
        vt[10] = '{3'b111, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0011};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(vt[i].op, vt[i].a, vt[i].b);
            @(negedge clk);
            bus.in_valid = 1'b0;
            nvec++; if (bus.out_valid !== 1'b1 || bus.out_result !== vt[i].r || bus.out_flags !== vt[i].f)
                begin nerr++; $display("FAIL vec%0d: got v=%b %h/%b expected v=1 %h/%b", i, bus.out_valid, bus.out_result, bus.out_flags, vt[i].r, vt[i].f); end
        end
    endtask
    task automatic test_backpressure;
        @(negedge clk);
        nvec++; if (op_count !== 16'd11 || bus.out_valid !== 1'b0) begin nerr++; $display("FAIL bp_start: got cnt=%0d v=%b expected cnt=11 v=0", op_count, bus.out_valid); end
        bus.out_ready = 1'b0;
        drive(3'b110, 32'd1, 32'd2);
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd3 || bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_first: got v=%b r=%h rdy=%b expected v=1 r=3 rdy=1", bus.out_valid, bus.out_result, bus.in_ready); end
        drive(3'b111, 32'd10, 32'd3);
        @(negedge clk);
        nvec++; if (bus.in_ready !== 1'b0 || bus.out_result !== 32'd3) begin nerr++; $display("FAIL bp_full: got rdy=%b r=%h expected rdy=0 r=3", bus.in_ready, bus.out_result); end
        drive(3'b011, 32'hF0, 32'h0F);
        @(negedge clk);
        nvec++; if (bus.in_ready !== 1'b0 || bus.out_result !== 32'd3) begin nerr++; $display("FAIL bp_hold: got rdy=%b r=%h expected rdy=0 r=3", bus.in_ready, bus.out_result); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        nvec++; if (bus.out_result !== 32'd7 || bus.out_flags !== 4'b0010 || bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_second: got r=%h f=%b rdy=%b expected r=7 f=0010 rdy=1", bus.out_result, bus.out_flags, bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        nvec++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'hFF) begin nerr++; $display("FAIL bp_third: got v=%b r=%h expected v=1 r=ff", bus.out_valid, bus.out_result); end
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b0 || op_count !== 16'd14) begin nerr++; $display("FAIL bp_drain: got v=%b cnt=%0d expected v=0 cnt=14", bus.out_valid, op_count); end
    endtask
    task automatic test_streaming;
        logic [35:0] exp_q [$];
        logic [35:0] e;
        logic [2:0]  op;
        logic [31:0] a, b;
        bus.out_ready = 1'b1;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                nvec++; if (bus.out_valid !== 1'b1 || {bus.out_flags, bus.out_result} !== e)
                    begin nerr++; $display("FAIL stream%0d: got v=%b %b/%h expected v=1 %b/%h", i - 1, bus.out_valid, bus.out_flags, bus.out_result, e[35:32], e[31:0]); end
            end
            if (i < 100) begin
                op = 3'($urandom_range(0, 7));
                a  = $urandom;
                b  = (i % 9 == 0) ? a : $urandom;
                drive(op, a, b);
                exp_q.push_back(model(op, a, b));
            end else
                bus.in_valid = 1'b0;
        end
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b0 || op_count !== 16'd114) begin nerr++; $display("FAIL stream_end: got v=%b cnt=%0d expected v=0 cnt=114", bus.out_valid, op_count); end
    endtask
    task automatic test_reset_mid_full;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(3'b110, 32'd5, 32'd6);
        @(negedge clk);
        drive(3'b100, 32'd5, 32'd6);
        @(negedge clk);
        bus.in_valid = 1'b0;
        nvec++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin nerr++; $display("FAIL mid_full: got rdy=%b v=%b expected rdy=0 v=1", bus.in_ready, bus.out_valid); end
        #2 reset = 1'b1;
        #1;
        nvec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || op_count !== 16'h0 || bus.out_result !== 32'h0 || bus.out_flags !== 4'h0)
            begin nerr++; $display("FAIL async_reset: got v=%b rdy=%b cnt=%h r=%h f=%b expected 0/1/0/0/0", bus.out_valid, bus.in_ready, op_count, bus.out_result, bus.out_flags); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nvec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin nerr++; $display("FAIL post_reset: got v=%b rdy=%b expected v=0 rdy=1", bus.out_valid, bus.in_ready); end
    endtask
    task automatic test_saturation;
        logic [15:0] exp_cnt [4];
        exp_cnt = '{16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        @(negedge clk);
        force dut.op_count = 16'hFFFE;
        #1 release dut.op_count;
        bus.out_ready = 1'b1;
        drive(3'b010, 32'hFF, 32'h0F);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nvec++; if (op_count !== exp_cnt[i]) begin nerr++; $display("FAIL sat%0d: got %h expected %h", i, op_count, exp_cnt[i]); end
            if (i < 2) drive(3'b011, 32'(i), 32'h100);
            else bus.in_valid = 1'b0;
        end
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL sat_drain: got v=%b expected 0", bus.out_valid); end
    endtask
    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_streaming();
        test_reset_mid_full();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
